// File: rtl/axi_rd_responder.sv
// ---------------------------------------------------------------------------
// axi_rd_responder
//   AXI4 read-channel responder sitting in front of an on-chip word memory.
//   One AR request is accepted at a time. The burst is then streamed on R,
//   one beat per cycle while rready is held high. A backdoor write port
//   preloads or updates the memory.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active low (0 = reset)
//   arid       request ID, returned on rid
//   araddr     start byte address; low bits below the word size are ignored
//   arlen      number of beats minus one
//   arburst    00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//   arvalid    request valid
//   arready    request accepted when arvalid & arready
//   rid        ID latched from arid
//   rdata      read data
//   rresp      00 OKAY, 10 SLVERR
//   rlast      final beat of the burst
//   rvalid     beat valid
//   rready     beat consumed when rvalid & rready
//   mem_we     backdoor write enable
//   mem_waddr  backdoor word index
//   mem_wdata  backdoor write data
// ---------------------------------------------------------------------------
module axi_rd_responder #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_W-1:0]              arid,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic [7:0]                   arlen,
    input  logic [1:0]                   arburst,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [ID_W-1:0]              rid,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic                         rvalid,
    input  logic                         rready,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_W-1:0]            mem_wdata
);

    localparam int SHIFT = $clog2(DATA_W / 8);   // byte-offset bits in a word
    localparam int IW    = ADDR_W - SHIFT;       // word-index width
    localparam int MAW   = $clog2(MEM_DEPTH);    // memory address width

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];
    logic [IW-1:0]       r_idx;
    logic [7:0]          r_len;
    logic [7:0]          r_cnt;
    logic [1:0]          r_burst;
    logic                r_arready;
    logic                r_rvalid;
    logic                r_rlast;
    logic [ID_W-1:0]     r_rid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;

    logic                w_ar_hs;
    logic                w_r_hs;
    logic [IW-1:0]       w_beat_idx;
    logic [1:0]          w_beat_burst;
    logic [7:0]          w_beat_cnt;
    logic [7:0]          w_beat_len;
    logic                w_beat_err;
    logic                w_beat_last;
    logic [MAW-1:0]      w_midx;
    logic [DATA_W-1:0]   w_beat_data;

    assign w_ar_hs = arvalid & r_arready;
    assign w_r_hs  = r_rvalid & rready;

    // Sub-word address bits carry no information for a word memory.
    generate
        if (SHIFT > 0) begin : g_lsb
            logic w_unused_lsb;
            assign w_unused_lsb = ^araddr[SHIFT-1:0];
        end
    endgenerate

    // Next beat to register: beat 0 comes straight from the AR channel while
    // idle, later beats step from the latched burst state.
    always_comb begin
        w_beat_idx   = r_idx;
        w_beat_burst = r_burst;
        w_beat_cnt   = r_cnt;
        w_beat_len   = r_len;
        if (r_state == S_IDLE) begin
            w_beat_idx   = araddr[ADDR_W-1:SHIFT];
            w_beat_burst = arburst;
            w_beat_cnt   = 8'd0;
            w_beat_len   = arlen;
        end else begin
            // INCR wraps naturally at the top of the index space.
            if (r_burst == BURST_INCR)
                w_beat_idx = r_idx + IW'(1);
            w_beat_cnt = r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_beat_err  = ((w_beat_burst != BURST_FIXED) && (w_beat_burst != BURST_INCR)) ||
                      (32'(w_beat_idx) >= 32'(MEM_DEPTH));
        w_beat_last = (w_beat_cnt == w_beat_len);
        w_midx      = MAW'(w_beat_idx);
        w_beat_data = '0;
        if (!w_beat_err)
            w_beat_data = r_mem[w_midx];
    end

    // Backdoor port. Non-blocking update makes a same-edge read see old data.
    always_ff @(posedge clk) begin
        if (mem_we)
            r_mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_cnt     <= 8'd0;
            r_len     <= 8'd0;
            r_idx     <= '0;
            r_burst   <= BURST_FIXED;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ar_hs) begin
                        r_state   <= S_BURST;
                        r_arready <= 1'b0;
                        r_rid     <= arid;
                        r_len     <= arlen;
                        r_burst   <= arburst;
                        r_idx     <= w_beat_idx;
                        r_cnt     <= w_beat_cnt;
                        r_rdata   <= w_beat_data;
                        r_rresp   <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
                        r_rlast   <= w_beat_last;
                        r_rvalid  <= 1'b1;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            // Re-open AR in the cycle right after the final beat.
                            r_state   <= S_IDLE;
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                        end else begin
                            r_idx   <= w_beat_idx;
                            r_cnt   <= w_beat_cnt;
                            r_rdata <= w_beat_data;
                            r_rresp <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
                            r_rlast <= w_beat_last;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi_rd_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_responder
//   Directed and randomized bursts against a reference model that computes
//   each expected beat from the burst rules (start index, beat number, burst
//   type) and a shadow copy of the memory.
// ---------------------------------------------------------------------------
module tb_axi_rd_responder;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 12;
    localparam int ID_W      = 4;
    localparam int MEM_DEPTH = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic              mem_we;
    logic [7:0]        mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [MEM_DEPTH];

    always #5 clk = ~clk;

    axi_rd_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beat k of a burst starting at word index 'start'.
    function automatic void model_beat(input int start, input int k, input logic [1:0] bt,
                                       output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = (bt == 2'b00) ? start : (start + k) % 1024;
        if (bt > 2'b01 || idx >= MEM_DEPTH) begin
            d = 32'h0;
            r = 2'b10;
        end else begin
            d = model_mem[idx];
            r = 2'b00;
        end
    endfunction

    task automatic wr(input int idx, input logic [31:0] d);
        mem_we    = 1'b1;
        mem_waddr = idx[7:0];
        mem_wdata = d;
        step();
        mem_we = 1'b0;
        model_mem[idx] = d;
    endtask

    // mode 0: rready always 1; 1: toggles 1,0,1,0; 2: random
    task automatic burst(input logic [3:0] id, input logic [11:0] addr, input int len,
                         input logic [1:0] bt, input int mode);
        int guard;
        int k;
        int start;
        logic rr;
        logic [31:0] ed;
        logic [1:0] er;
        start   = int'(addr) >> 2;
        arid    = id;
        araddr  = addr;
        arlen   = len[7:0];
        arburst = bt;
        arvalid = 1'b1;
        guard   = 0;
        while (arready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        chk("ar_ready", arready, 1);
        step();
        arvalid = 1'b0;
        arid    = 4'($urandom);
        araddr  = 12'($urandom);
        arlen   = 8'($urandom);
        arburst = 2'($urandom);
        chk("ar_closed", arready, 0);
        k = 0;
        guard = 0;
        while (k <= len && guard < 400) begin
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (guard % 2 == 0);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            rready = rr;
            model_beat(start, k, bt, ed, er);
            chk("rvalid", rvalid, 1);
            chk("rid", rid, id);
            chk("rdata", rdata, ed);
            chk("rresp", rresp, er);
            chk("rlast", rlast, (k == len));
            step();
            if (rr) k++;
            guard++;
        end
        rready = 1'b0;
        chk("beats", k, len + 1);
        chk("rvalid_end", rvalid, 0);
        chk("arready_end", arready, 1);
    endtask

    initial begin
        logic [11:0] ra;
        logic [1:0]  rb;
        rst = 1'b0; arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

        // Reset held two cycles
        step();
        step();
        chk("rst_rvalid", rvalid, 0);
        chk("rst_arready", arready, 0);
        rst = 1'b1;
        step();
        chk("post_rst_arready", arready, 1);
        chk("post_rst_rvalid", rvalid, 0);
        chk("post_rst_rresp", rresp, 0);
        chk("post_rst_rid", rid, 0);
        chk("post_rst_rdata", rdata, 0);
        chk("post_rst_rlast", rlast, 0);

        for (int i = 0; i < MEM_DEPTH; i++) wr(i, i);
        wr(4, 32'hA5A5_0004);
        wr(255, 32'hDEAD_00FF);

        // Directed bursts
        burst(4'd3, 12'h010, 0, 2'b01, 0);
        wr(4, 32'd4);
        burst(4'd1, 12'h000, 3, 2'b01, 0);
        burst(4'd2, 12'h000, 3, 2'b01, 1);
        burst(4'd5, 12'h008, 2, 2'b00, 0);
        burst(4'd6, 12'h3FC, 1, 2'b01, 0);
        burst(4'd7, 12'hFFC, 2, 2'b01, 2);
        burst(4'd8, 12'h020, 1, 2'b10, 0);
        burst(4'd9, 12'h021, 2, 2'b11, 1);

        // Backdoor write at the same edge beat 0 is registered
        arid = 4'd4; araddr = 12'h028; arlen = 8'd1; arburst = 2'b00; arvalid = 1'b1;
        mem_we = 1'b1; mem_waddr = 8'd10; mem_wdata = 32'h1234_5678; rready = 1'b1;
        step();
        arvalid = 1'b0;
        mem_we  = 1'b0;
        chk("rbw_beat0", rdata, 32'd10);
        chk("rbw_last0", rlast, 0);
        model_mem[10] = 32'h1234_5678;
        step();
        chk("rbw_beat1", rdata, 32'h1234_5678);
        chk("rbw_last1", rlast, 1);
        step();
        chk("rbw_done", rvalid, 0);
        rready = 1'b0;

        // Reset in the middle of a burst
        arid = 4'd1; araddr = 12'h000; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
        rready = 1'b1;
        step();
        arvalid = 1'b0;
        chk("mid_beat0", rdata, 0);
        step();
        step();
        step();
        chk("mid_beat3", rdata, 3);
        rst = 1'b0;
        step();
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_rlast", rlast, 0);
        chk("mid_rst_arready", arready, 0);
        rst = 1'b1;
        rready = 1'b0;
        step();
        chk("mid_rel_arready", arready, 1);
        chk("mid_rel_rvalid", rvalid, 0);
        burst(4'd2, 12'h014, 0, 2'b01, 0);

        // Randomized bursts
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0)
                wr($urandom_range(0, MEM_DEPTH - 1), $urandom);
            ra = ($urandom_range(0, 3) != 0) ? 12'($urandom_range(0, 12'h3FF)) : 12'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            burst(4'($urandom), ra, $urandom_range(0, 15), rb, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
